thermometer_serializer: RTL

//  Transmit-side counterpart of the serial thermometer counter: accepts one signed two's-complement value,

---
 rtl/thermo_pkg.sv | 19 +
 rtl/thermo_offset_remove.sv | 39 +++
 rtl/thermometer_serializer.sv | 116 +++++++++++
 3 files changed

// File: rtl/thermo_pkg.sv
// Shared definitions for the serial thermometer path: width helpers and FSM states.
package thermo_pkg;

  // Width of the signed bipolar value carried on the thermometer path.
  function automatic int VAL_W(input int n);
    return $clog2(n) + 2;
  endfunction

  // Width of a ones count / bit index, able to hold 0..n.
  function automatic int CNT_W(input int n);
    return $clog2(n) + 1;
  endfunction

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } thermo_state_e;

endpackage

// File: rtl/thermo_offset_remove.sv
// Removes the bipolar offset from a signed value, giving the number of ones in
// a thermometer frame. Inverse of the counter's offset stage (value = 2*count - N).
module thermo_offset_remove
  import thermo_pkg::*;
#(
  parameter int SERIAL_INPUT_LENGTH = 64
) (
  input  logic signed [VAL_W(SERIAL_INPUT_LENGTH)-1:0] value_in,
  output logic        [CNT_W(SERIAL_INPUT_LENGTH)-1:0] count,
  output logic                                         sat,
  output logic                                         par_err
);

  localparam int N  = SERIAL_INPUT_LENGTH;
  localparam int VW = VAL_W(N);
  localparam int SW = VW + 1;
  localparam int CW = CNT_W(N);
  localparam logic signed [SW-1:0] N_S = SW'(N);

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] half;

  // Clamp the halved sum into 0..N; the top bit of the result flags saturation.
  function automatic logic [CW:0] saturate(input logic signed [SW-1:0] h);
    if (h[SW-1])
      return {1'b1, CW'(0)};
    else if (h > N_S)
      return {1'b1, CW'(N)};
    else
      return {1'b0, h[CW-1:0]};
  endfunction

  // One extra bit of headroom keeps value_in + N from overflowing.
  assign sum            = $signed({value_in[VW-1], value_in}) + N_S;
  assign half           = sum >>> 1;
  assign {sat, count}   = saturate(half);
  assign par_err        = sum[0];

endmodule

// File: rtl/thermometer_serializer.sv
// Serializes a signed value into an N-bit thermometer frame, one bit per clock,
// with frame_start on the first bit and a done pulse after the last.
module thermometer_serializer
  import thermo_pkg::*;
#(
  parameter int SERIAL_INPUT_LENGTH = 64,
  parameter bit ONES_FIRST          = 1'b1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic signed [VAL_W(SERIAL_INPUT_LENGTH)-1:0] value_in,
  output logic                                         ready,
  output logic                                         serial_out,
  output logic                                         serial_valid,
  output logic                                         frame_start,
  output logic                                         done,
  output logic                                         sat_flag,
  output logic                                         parity_err
);

  localparam int N  = SERIAL_INPUT_LENGTH;
  localparam int CW = CNT_W(N);

  thermo_state_e   state_p0, state_d;
  logic [CW-1:0]   idx_p0, idx_d;
  logic [CW-1:0]   count_p0;
  logic [CW-1:0]   count_c;
  logic            sat_c, par_c;
  logic            load;
  logic            bit_d, vld_d, fs_d, done_d;

  thermo_offset_remove #(
    .SERIAL_INPUT_LENGTH(N)
  ) u_offset (
    .value_in (value_in),
    .count    (count_c),
    .sat      (sat_c),
    .par_err  (par_c)
  );

  // Idle only once the last bit has left the output register.
  assign ready = (state_p0 == IDLE) && !serial_valid;

  // Next state, next idx and next registered outputs.
  always_comb begin
    state_d = state_p0;
    idx_d   = idx_p0;
    load    = 1'b0;
    bit_d   = 1'b0;
    vld_d   = 1'b0;
    fs_d    = 1'b0;
    done_d  = 1'b0;
    case (state_p0)
      IDLE: begin
        done_d = serial_valid;
        if (start && !serial_valid) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        vld_d = 1'b1;
        fs_d  = (idx_p0 == '0);
        if (ONES_FIRST)
          bit_d = (idx_p0 < count_p0);
        else
          bit_d = (idx_p0 >= (CW'(N) - count_p0));
        idx_d = idx_p0 + CW'(1);
        if (idx_p0 == CW'(N - 1))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index and per-frame flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0   <= IDLE;
      idx_p0     <= '0;
      sat_flag   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state_p0 <= state_d;
      idx_p0   <= idx_d;
      if (load) begin
        sat_flag   <= sat_c;
        parity_err <= par_c;
      end
    end
  end

  // Captured ones count; a data register, only written on accept.
  always_ff @(posedge clk) begin
    if (load)
      count_p0 <= count_c;
  end

  // Registered serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      done         <= 1'b0;
    end else begin
      serial_out   <= bit_d;
      serial_valid <= vld_d;
      frame_start  <= fs_d;
      done         <= done_d;
    end
  end

endmodule
